mux_sweep_driver: RTL and testbench



---
 rtl/mux_sweep_pkg.sv | 19 +
 rtl/mux_sweep_driver_hold_counter.sv | 33 +++
 rtl/mux_sweep_driver.sv | 96 +++++++++
 tb/tb_mux_sweep_driver.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_sweep_pkg.sv
// Shared types and constants for the mux sweep driver: FSM states and the
// code/hold widths used by the top and its hold counter.
package mux_sweep_pkg;

  localparam int CODE_W    = 3;
  localparam int NUM_CODES = 8;
  localparam int HOLD_W    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic is_last_code(input logic [CODE_W-1:0] code);
    return code == CODE_W'(NUM_CODES - 1);
  endfunction

endpackage

// File: rtl/mux_sweep_driver_hold_counter.sv
// Hold-window counter: counts cycles a code has been driven and flags the
// cycle in which the window closes (count == HOLD_CYCLES-1).
module sweep_hold_counter
  import mux_sweep_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic terminal
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [HOLD_W-1:0] count_q;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign terminal = (count_q == HOLD_LAST);

endmodule

// File: rtl/mux_sweep_driver.sv
// Sweeps {a,b,c} through all 8 codes, holding each for HOLD_CYCLES cycles,
// and captures the mux block's f output at the end of each window.
module mux_sweep_driver
  import mux_sweep_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       f_in,
  output logic       a_out,
  output logic       b_out,
  output logic       c_out,
  output logic       busy,
  output logic       done,
  output logic       table_valid,
  output logic [7:0] truth_table
);

  state_t            state_q, state_d;
  logic [CODE_W-1:0] code_q;
  logic              hold_term;
  logic              start_ok;
  logic              step;

  assign start_ok = (state_q == IDLE)  && start && !abort;
  assign step     = (state_q == DRIVE) && hold_term && !abort;

  // Counter is held at zero outside DRIVE, so every sweep starts a fresh window.
  sweep_hold_counter #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    ((state_q != DRIVE) || hold_term),
    .en       (state_q == DRIVE),
    .terminal (hold_term)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: next-state is assigned a default before any branch so the
  // combinational process can never infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_ok) state_d = DRIVE;
      DRIVE:   if (abort) state_d = IDLE;
               else if (step && is_last_code(code_q)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      DRIVE:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Abort freezes the code and keeps partial captures; only validity drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q      <= '0;
      truth_table <= '0;
      table_valid <= 1'b0;
    end else if (start_ok) begin
      code_q      <= '0;
      truth_table <= '0;
      table_valid <= 1'b0;
    end else if (abort) begin
      table_valid <= 1'b0;
    end else begin
      if (step) begin
        truth_table[code_q] <= f_in;
        if (!is_last_code(code_q)) code_q <= code_q + 1'b1;
      end
      if (state_q == DONE) table_valid <= 1'b1;
    end
  end

  assign {a_out, b_out, c_out} = code_q;

endmodule

// File: tb/tb_mux_sweep_driver.sv
// Scoreboard bench: stimulus pushes the expected truth table and start edge;
// per-DUT monitors pop and compare whenever done pulses.
module tb_mux_sweep_driver;

  typedef struct {
    logic [7:0] tt;
    int         start_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // DUT with HOLD_CYCLES=4
  logic       start4 = 0, abort4 = 0, f4;
  logic       a4, b4, c4, busy4, done4, tv4;
  logic [7:0] tt4;
  logic       use_mux4 = 1;
  logic [7:0] src4 = 8'h00;

  // Behaviour of the 3-input mux function block: f = 1 for codes 4, 5, 7.
  function automatic logic mux_block(input logic a, input logic b, input logic c);
    return a & (~b | c);
  endfunction

  assign f4 = use_mux4 ? mux_block(a4, b4, c4) : src4[{a4, b4, c4}];

  mux_sweep_driver #(.HOLD_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4), .f_in(f4),
    .a_out(a4), .b_out(b4), .c_out(c4), .busy(busy4), .done(done4),
    .table_valid(tv4), .truth_table(tt4)
  );

  // DUT with HOLD_CYCLES=1
  logic       start1 = 0, abort1 = 0, f1;
  logic       a1, b1, c1, busy1, done1, tv1;
  logic [7:0] tt1;
  logic       xor_mode1 = 1;
  logic [7:0] src1 = 8'h00;

  assign f1 = xor_mode1 ? (a1 ^ c1) : src1[{a1, b1, c1}];

  mux_sweep_driver #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .f_in(f1),
    .a_out(a1), .b_out(b1), .c_out(c1), .busy(busy1), .done(done1),
    .table_valid(tv1), .truth_table(tt1)
  );

  exp_t q4[$];
  exp_t q1[$];

  // Monitors: compare on every done pulse, then confirm table_valid next cycle.
  bit tv_pend4 = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (tv_pend4) begin
        check("h4_table_valid_after_done", {30'd0, tv4, done4}, 32'd2);
        tv_pend4 = 0;
      end
      if (done4) begin
        check("h4_busy_in_done", busy4, 0);
        if (q4.size() == 0) begin
          check("h4_unexpected_done", 1, 0);
        end else begin
          e = q4.pop_front();
          check("h4_truth_table", tt4, e.tt);
          check("h4_start_to_done", cyc - e.start_cyc, 32);
          tv_pend4 = 1;
        end
      end
    end else begin
      tv_pend4 = 0;
    end
  end

  bit tv_pend1 = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (tv_pend1) begin
        check("h1_table_valid_after_done", {30'd0, tv1, done1}, 32'd2);
        tv_pend1 = 0;
      end
      if (done1) begin
        if (q1.size() == 0) begin
          check("h1_unexpected_done", 1, 0);
        end else begin
          e = q1.pop_front();
          check("h1_truth_table", tt1, e.tt);
          check("h1_start_to_done", cyc - e.start_cyc, 8);
          tv_pend1 = 1;
        end
      end
    end else begin
      tv_pend1 = 0;
    end
  end

  // Issue start on dut4 and push expectation; returns at the negedge after E0.
  task automatic issue4(input logic [7:0] exp_tt);
    exp_t e;
    @(negedge clk);
    start4 = 1;
    e.tt = exp_tt;
    e.start_cyc = cyc + 1;
    q4.push_back(e);
    @(negedge clk);
    start4 = 0;
  endtask

  // Count busy cycles until done (bounded), then let the monitor see table_valid.
  task automatic finish4(input bit poke_start);
    int n = 0;
    bit seen = 0;
    for (int i = 0; i < 400; i++) begin
      if (done4) begin seen = 1; break; end
      if (busy4) n++;
      if (poke_start && i == 10) start4 = 1;
      if (poke_start && i == 11) start4 = 0;
      @(negedge clk);
    end
    check("h4_done_seen", seen, 1);
    check("h4_busy_cycles", n, 32);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic wait_code4(input logic [2:0] code);
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (busy4 && {a4, b4, c4} == code) begin ok = 1; break; end
      @(negedge clk);
    end
    check("h4_reach_code", ok, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [7:0] r;
    int dones;

    // Reset, then idle with start low.
    repeat (3) @(negedge clk);
    check("reset_outputs_h4", {a4, b4, c4, busy4, done4, tv4, tt4}, 0);
    check("reset_outputs_h1", {a1, b1, c1, busy1, done1, tv1, tt1}, 0);
    rst_n = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_outputs_h4", {a4, b4, c4, busy4, done4, tv4, tt4}, 0);
    end

    // Full sweep through the mux block.
    use_mux4 = 1;
    issue4(8'hB0);
    finish4(0);
    check("h4_codes_hold_last", {a4, b4, c4}, 3'b111);

    // Walk codes one per cycle with f = a ^ c.
    xor_mode1 = 1;
    @(negedge clk);
    start1 = 1;
    e.tt = 8'b0101_1010;
    e.start_cyc = cyc + 1;
    q1.push_back(e);
    @(negedge clk);
    start1 = 0;
    for (int i = 0; i < 8; i++) begin
      check("h1_walk_code", {a1, b1, c1}, i);
      check("h1_busy_walk", busy1, 1);
      @(negedge clk);
    end
    check("h1_done_after_8", done1, 1);
    repeat (3) @(negedge clk);

    // Abort at code 3: partial table kept, no done, validity cleared.
    use_mux4 = 1;
    issue4(8'hB0);
    wait_code4(3'd3);
    abort4 = 1;
    @(negedge clk);
    abort4 = 0;
    void'(q4.pop_back());
    check("abort_busy", busy4, 0);
    check("abort_table_valid", tv4, 0);
    check("abort_done", done4, 0);
    r = tt4;
    check("abort_upper_bits_clear", r[7:3], 0);
    check("abort_code_frozen", {a4, b4, c4}, 3'd3);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done4) dones++;
    end
    check("abort_no_done", dones, 0);
    check("abort_code_still_frozen", {a4, b4, c4}, 3'd3);

    // Abort together with start in IDLE: no sweep.
    @(negedge clk);
    start4 = 1; abort4 = 1;
    @(negedge clk);
    start4 = 0; abort4 = 0;
    check("abort_start_idle_busy", busy4, 0);

    // Start re-asserted during DRIVE is ignored.
    issue4(8'hB0);
    finish4(1);

    // Randomized tables on both instances.
    use_mux4 = 0;
    xor_mode1 = 0;
    for (int k = 0; k < 6; k++) begin
      src4 = 8'($urandom);
      issue4(src4);
      finish4(0);
      src1 = 8'($urandom);
      @(negedge clk);
      start1 = 1;
      e.tt = src1;
      e.start_cyc = cyc + 1;
      q1.push_back(e);
      @(negedge clk);
      start1 = 0;
      repeat (8 + $urandom_range(1, 4)) @(negedge clk);
    end

    // Asynchronous reset mid-sweep at code 5.
    src4 = 8'($urandom);
    issue4(src4);
    wait_code4(3'd5);
    #2 rst_n = 0;
    #1;
    check("async_reset_outputs", {a4, b4, c4, busy4, done4, tv4, tt4}, 0);
    q4.delete();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    src4 = 8'($urandom);
    issue4(src4);
    finish4(0);

    check("scoreboard_drained", q4.size() + q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
